viterbi_output_unpack: RTL and testbench

//  Stage directly downstream of the viterbi decoder. Consumes the decided 3-bit symbol `out` and the `error` flag.

---
 rtl/viterbi_pkg.sv | 27 ++
 rtl/viterbi_word_fifo.sv | 53 +++++
 rtl/viterbi_output_unpack.sv | 168 ++++++++++++++++
 tb/tb_viterbi_output_unpack.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// Shared constants and types for the viterbi output stage.
package viterbi_pkg;

  localparam int unsigned SYM_W      = 3;
  localparam int unsigned VIT_WARMUP = 12;
  localparam int unsigned PH_W       = 2;

  localparam logic [PH_W-1:0] PH_WARM  = 2'd0;
  localparam logic [PH_W-1:0] PH_PRIME = 2'd1;
  localparam logic [PH_W-1:0] PH_RUN   = 2'd2;

  typedef logic [PH_W-1:0] phase_t;

  // Recovered data bit pair, X2N on the upper bit.
  typedef struct packed {
    logic x2;
    logic x1;
  } pair_t;

  // Y1N(n-1) must equal Y0N(n) ^ Y0N(n-2).
  function automatic logic parity_fail(input logic h2_y0,
                                       input logic h1_y1,
                                       input logic s_y0);
    return h1_y1 != (s_y0 ^ h2_y0);
  endfunction

endpackage

// File: rtl/viterbi_word_fifo.sv
// First-word-fall-through word FIFO; pointers carry an extra wrap bit.
module viterbi_word_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             full_o,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o
);

  localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PTR_W  = ADDR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             full_c, empty_c, wr_en_c, rd_en_c;

  // A push into a full FIFO is taken only when a pop frees the head slot.
  always_comb begin
    empty_c  = (wr_ptr_q == rd_ptr_q);
    full_c   = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
               (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    rd_en_c  = pop_i && !empty_c;
    wr_en_c  = push_i && (!full_c || rd_en_c);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_en_c) rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (wr_en_c) mem_q[wr_ptr_q[ADDR_W-1:0]] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q[ADDR_W-1:0]];
  assign full_o  = full_c;
  assign empty_o = empty_c;

endmodule

// File: rtl/viterbi_output_unpack.sv
// Post-decoder stage: drops warm-up symbols, rebuilds {X2N,X1N} pairs,
// checks Y1N parity and packs pairs into words behind a FIFO.
module viterbi_output_unpack
  import viterbi_pkg::*;
#(
  parameter int unsigned WORD_W     = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned WARMUP     = VIT_WARMUP,
  parameter int unsigned CNT_W      = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              sym_en,
  input  logic [SYM_W-1:0]  sym_in,
  input  logic              dec_error,
  output logic [WORD_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  input  logic              clr_status,
  output logic [CNT_W-1:0]  parity_err_cnt,
  output logic [CNT_W-1:0]  dec_err_cnt,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic              overflow
);

  localparam int unsigned WARM_W    = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam int unsigned WARM_LAST = (WARMUP > 0) ? WARMUP - 1 : 0;
  localparam int unsigned PAIRS     = WORD_W / 2;
  localparam int unsigned PIDX_W    = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam int unsigned PAIR_LAST = PAIRS - 1;
  localparam phase_t      RST_PHASE = (WARMUP == 0) ? PH_PRIME : PH_WARM;

  phase_t              phase_q, phase_d;
  logic [WARM_W-1:0]   warm_cnt_q, warm_cnt_d;
  logic [SYM_W-1:0]    h1_q, h1_d;
  logic                h2_y0_q, h2_y0_d;
  logic                h2_vld_q, h2_vld_d;
  logic [PIDX_W-1:0]   pidx_q, pidx_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [CNT_W-1:0]    par_cnt_q, par_cnt_d;
  logic [CNT_W-1:0]    dec_cnt_q, dec_cnt_d;
  logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;
  logic                ovf_q, ovf_d;

  pair_t               pair_c;
  logic                push_c, par_fail_c, dec_inc_c, drop_c;
  logic                fifo_full_c, fifo_empty_c, pop_c;
  logic [WORD_W-1:0]   fifo_rdata_c;

  assign pop_c = !fifo_empty_c && m_ready;

  // Phase FSM, history, pair packing and status counters.
  always_comb begin
    phase_d    = phase_q;
    warm_cnt_d = warm_cnt_q;
    h1_d       = h1_q;
    h2_y0_d    = h2_y0_q;
    h2_vld_d   = h2_vld_q;
    pidx_d     = pidx_q;
    word_d     = word_q;
    par_cnt_d  = par_cnt_q;
    dec_cnt_d  = dec_cnt_q;
    drop_cnt_d = drop_cnt_q;
    ovf_d      = ovf_q;
    pair_c     = '0;
    push_c     = 1'b0;
    par_fail_c = 1'b0;

    case (phase_q)
      PH_WARM: begin
        if (sym_en) begin
          if (warm_cnt_q == WARM_W'(WARM_LAST)) phase_d = PH_PRIME;
          else warm_cnt_d = warm_cnt_q + WARM_W'(1);
        end
      end
      PH_PRIME: begin
        if (sym_en) begin
          h1_d    = sym_in;
          phase_d = PH_RUN;
        end
      end
      PH_RUN: begin
        if (sym_en) begin
          pair_c     = '{x2: h1_q[2], x1: sym_in[0]};
          par_fail_c = h2_vld_q && parity_fail(h2_y0_q, h1_q[1], sym_in[0]);
          h2_y0_d    = h1_q[0];
          h2_vld_d   = 1'b1;
          h1_d       = sym_in;
          // Pairs enter at the top so the first pair ends up in bits [1:0].
          word_d     = {pair_c, word_q[WORD_W-1:2]};
          if (pidx_q == PIDX_W'(PAIR_LAST)) begin
            push_c = 1'b1;
            pidx_d = '0;
          end else begin
            pidx_d = pidx_q + PIDX_W'(1);
          end
        end
      end
      default: phase_d = RST_PHASE;
    endcase

    dec_inc_c = sym_en && dec_error && (phase_q != PH_WARM);
    drop_c    = push_c && fifo_full_c && !pop_c;

    // Saturating counters; a clear beats a same-cycle increment.
    if (clr_status) begin
      par_cnt_d  = '0;
      dec_cnt_d  = '0;
      drop_cnt_d = '0;
      ovf_d      = 1'b0;
    end else begin
      if (par_fail_c && (par_cnt_q != '1))  par_cnt_d  = par_cnt_q + CNT_W'(1);
      if (dec_inc_c && (dec_cnt_q != '1))   dec_cnt_d  = dec_cnt_q + CNT_W'(1);
      if (drop_c && (drop_cnt_q != '1))     drop_cnt_d = drop_cnt_q + CNT_W'(1);
      if (drop_c)                           ovf_d      = 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      phase_q    <= RST_PHASE;
      warm_cnt_q <= '0;
      h1_q       <= '0;
      h2_y0_q    <= 1'b0;
      h2_vld_q   <= 1'b0;
      pidx_q     <= '0;
      word_q     <= '0;
      par_cnt_q  <= '0;
      dec_cnt_q  <= '0;
      drop_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      warm_cnt_q <= warm_cnt_d;
      h1_q       <= h1_d;
      h2_y0_q    <= h2_y0_d;
      h2_vld_q   <= h2_vld_d;
      pidx_q     <= pidx_d;
      word_q     <= word_d;
      par_cnt_q  <= par_cnt_d;
      dec_cnt_q  <= dec_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  viterbi_word_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .Clock   (Clock),
    .Reset   (Reset),
    .push_i  (push_c),
    .wdata_i (word_d),
    .full_o  (fifo_full_c),
    .pop_i   (pop_c),
    .rdata_o (fifo_rdata_c),
    .empty_o (fifo_empty_c)
  );

  assign m_data         = fifo_rdata_c;
  assign m_valid        = !fifo_empty_c;
  assign parity_err_cnt = par_cnt_q;
  assign dec_err_cnt    = dec_cnt_q;
  assign drop_cnt       = drop_cnt_q;
  assign overflow       = ovf_q;

endmodule

// File: tb/tb_viterbi_output_unpack.sv
// Directed bench for viterbi_output_unpack fed by a rate-2/3 encoder model.
module tb_viterbi_output_unpack;

  localparam int unsigned WORD_W     = 4;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned WARMUP     = 2;
  localparam int unsigned CNT_W      = 8;

  logic              Clock = 1'b0;
  logic              Reset;
  logic              sym_en;
  logic [2:0]        sym_in;
  logic              dec_error;
  logic [WORD_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              clr_status;
  logic [CNT_W-1:0]  parity_err_cnt;
  logic [CNT_W-1:0]  dec_err_cnt;
  logic [CNT_W-1:0]  drop_cnt;
  logic              overflow;

  int checks = 0;
  int errors = 0;

  // Encoder state: X1N of the previous two symbols.
  logic x1_d1, x1_d2;

  logic [1:0] d3 [12] = '{2'b01, 2'b11, 2'b00, 2'b01, 2'b11, 2'b10,
                          2'b10, 2'b00, 2'b01, 2'b11, 2'b11, 2'b00};
  logic [3:0] exp3 [4] = '{4'b0110, 4'b0011, 4'b1101, 4'b1010};
  logic [1:0] e4 [10] = '{2'b01, 2'b10, 2'b01, 2'b11, 2'b10,
                          2'b00, 2'b11, 2'b01, 2'b10, 2'b11};
  logic [3:0] exp4 [4] = '{4'b0110, 4'b1011, 4'b1100, 4'b1001};

  always #5 Clock = ~Clock;

  viterbi_output_unpack #(
    .WORD_W     (WORD_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .WARMUP     (WARMUP),
    .CNT_W      (CNT_W)
  ) dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .sym_en         (sym_en),
    .sym_in         (sym_in),
    .dec_error      (dec_error),
    .m_data         (m_data),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .clr_status     (clr_status),
    .parity_err_cnt (parity_err_cnt),
    .dec_err_cnt    (dec_err_cnt),
    .drop_cnt       (drop_cnt),
    .overflow       (overflow)
  );

  task automatic enc_reset();
    x1_d1 = 1'b0;
    x1_d2 = 1'b0;
  endtask

  task automatic idle();
    sym_en = 1'b0;
    @(negedge Clock);
    clr_status = 1'b0;
  endtask

  task automatic send_raw(input logic [2:0] s, input logic err);
    sym_en    = 1'b1;
    sym_in    = s;
    dec_error = err;
    @(negedge Clock);
    sym_en     = 1'b0;
    dec_error  = 1'b0;
    clr_status = 1'b0;
  endtask

  // Y2N = X2N, Y1N = X1N ^ X1N(n-2), Y0N = X1N(n-1).
  task automatic send_data(input logic [1:0] d, input logic err, input logic flip);
    logic [2:0] s;
    s = {d[1], d[0] ^ x1_d2 ^ flip, x1_d1};
    x1_d2 = x1_d1;
    x1_d1 = d[0];
    send_raw(s, err);
  endtask

  task automatic do_reset();
    Reset  = 1'b1;
    sym_en = 1'b0;
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; sym_en = 1'b0; sym_in = '0; dec_error = 1'b0;
    m_ready = 1'b1; clr_status = 1'b0;
    enc_reset();
    do_reset();
    checks++;
    if (m_valid !== 1'b0 || m_data !== 4'b0000) begin
      errors++; $display("FAIL reset_fifo valid=%b data=%b exp 0/0000", m_valid, m_data);
    end
    checks++;
    if (parity_err_cnt !== 8'd0 || dec_err_cnt !== 8'd0 || drop_cnt !== 8'd0 || overflow !== 1'b0) begin
      errors++; $display("FAIL reset_status par=%0d dec=%0d drop=%0d ovf=%b exp all 0",
                         parity_err_cnt, dec_err_cnt, drop_cnt, overflow);
    end
  endtask

  task automatic test_unpack();
    send_raw(3'b101, 1'b0);
    send_raw(3'b110, 1'b0);
    enc_reset();
    send_data(2'b11, 1'b0, 1'b0);
    send_data(2'b01, 1'b0, 1'b0);
    checks++;
    if (m_valid !== 1'b0) begin
      errors++; $display("FAIL unpack_early_valid got %b exp 0", m_valid);
    end
    send_data(2'b10, 1'b0, 1'b0);
    checks++;
    if (m_valid !== 1'b1 || m_data !== 4'b0111) begin
      errors++; $display("FAIL unpack_word0 valid=%b data=%b exp 1/0111", m_valid, m_data);
    end
    send_data(2'b00, 1'b0, 1'b0);
    checks++;
    if (m_valid !== 1'b0) begin
      errors++; $display("FAIL unpack_pop valid=%b exp 0", m_valid);
    end
    send_data(2'b01, 1'b0, 1'b0);
    checks++;
    if (m_valid !== 1'b1 || m_data !== 4'b0010) begin
      errors++; $display("FAIL unpack_word1 valid=%b data=%b exp 1/0010", m_valid, m_data);
    end
    checks++;
    if (parity_err_cnt !== 8'd0) begin
      errors++; $display("FAIL unpack_parity got %0d exp 0", parity_err_cnt);
    end
  endtask

  task automatic test_parity();
    send_data(2'b10, 1'b0, 1'b1);
    checks++;
    if (parity_err_cnt !== 8'd0) begin
      errors++; $display("FAIL parity_before got %0d exp 0", parity_err_cnt);
    end
    send_data(2'b11, 1'b0, 1'b0);
    checks++;
    if (parity_err_cnt !== 8'd1 || m_valid !== 1'b1 || m_data !== 4'b1001) begin
      errors++; $display("FAIL parity_flip cnt=%0d valid=%b data=%b exp 1/1/1001",
                         parity_err_cnt, m_valid, m_data);
    end
    send_data(2'b00, 1'b0, 1'b0);
    send_data(2'b10, 1'b0, 1'b0);
    checks++;
    if (parity_err_cnt !== 8'd1 || m_data !== 4'b0011) begin
      errors++; $display("FAIL parity_after cnt=%0d data=%b exp 1/0011", parity_err_cnt, m_data);
    end
    idle();
    checks++;
    if (m_valid !== 1'b0) begin
      errors++; $display("FAIL parity_drain valid=%b exp 0", m_valid);
    end
  endtask

  task automatic test_overflow();
    m_ready = 1'b0;
    for (int i = 0; i < 12; i++) send_data(d3[i], 1'b0, 1'b0);
    checks++;
    if (drop_cnt !== 8'd2 || overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_status drop=%0d ovf=%b exp 2/1", drop_cnt, overflow);
    end
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (m_valid !== 1'b1 || m_data !== exp3[i]) begin
        errors++; $display("FAIL ovf_drain%0d valid=%b data=%b exp 1/%b", i, m_valid, m_data, exp3[i]);
      end
      idle();
    end
    checks++;
    if (m_valid !== 1'b0) begin
      errors++; $display("FAIL ovf_empty valid=%b exp 0", m_valid);
    end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 10; i++) begin
      m_ready = (i == 8);
      send_data(e4[i], 1'b0, 1'b0);
    end
    m_ready = 1'b0;
    checks++;
    if (drop_cnt !== 8'd2) begin
      errors++; $display("FAIL fpp_drop got %0d exp 2", drop_cnt);
    end
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (m_valid !== 1'b1 || m_data !== exp4[i]) begin
        errors++; $display("FAIL fpp_drain%0d valid=%b data=%b exp 1/%b", i, m_valid, m_data, exp4[i]);
      end
      idle();
    end
    checks++;
    if (m_valid !== 1'b0) begin
      errors++; $display("FAIL fpp_empty valid=%b exp 0", m_valid);
    end
    clr_status = 1'b1;
    idle();
    checks++;
    if (drop_cnt !== 8'd0 || overflow !== 1'b0) begin
      errors++; $display("FAIL clr_drop drop=%0d ovf=%b exp 0/0", drop_cnt, overflow);
    end
  endtask

  task automatic test_dec_err_clr();
    do_reset();
    send_raw(3'b111, 1'b1);
    send_raw(3'b000, 1'b0);
    checks++;
    if (dec_err_cnt !== 8'd0) begin
      errors++; $display("FAIL dec_warm got %0d exp 0", dec_err_cnt);
    end
    enc_reset();
    send_data(2'b11, 1'b1, 1'b0);
    send_data(2'b10, 1'b1, 1'b0);
    send_data(2'b01, 1'b1, 1'b0);
    checks++;
    if (m_valid !== 1'b1 || m_data !== 4'b1011) begin
      errors++; $display("FAIL dec_word valid=%b data=%b exp 1/1011", m_valid, m_data);
    end
    send_data(2'b00, 1'b0, 1'b1);
    checks++;
    if (dec_err_cnt !== 8'd3 || parity_err_cnt !== 8'd0) begin
      errors++; $display("FAIL dec_count dec=%0d par=%0d exp 3/0", dec_err_cnt, parity_err_cnt);
    end
    clr_status = 1'b1;
    send_data(2'b11, 1'b0, 1'b0);
    checks++;
    if (parity_err_cnt !== 8'd0 || dec_err_cnt !== 8'd0) begin
      errors++; $display("FAIL clr_wins par=%0d dec=%0d exp 0/0", parity_err_cnt, dec_err_cnt);
    end
    send_data(2'b00, 1'b0, 1'b0);
    checks++;
    if (parity_err_cnt !== 8'd0) begin
      errors++; $display("FAIL clr_after par=%0d exp 0", parity_err_cnt);
    end
  endtask

  task automatic test_reset_mid_word();
    m_ready = 1'b0;
    send_data(2'b01, 1'b1, 1'b0);
    checks++;
    if (m_valid !== 1'b1 || m_data !== 4'b0011 || dec_err_cnt !== 8'd1) begin
      errors++; $display("FAIL mid_pre valid=%b data=%b dec=%0d exp 1/0011/1", m_valid, m_data, dec_err_cnt);
    end
    send_data(2'b10, 1'b0, 1'b0);
    do_reset();
    checks++;
    if (m_valid !== 1'b0 || dec_err_cnt !== 8'd0 || parity_err_cnt !== 8'd0) begin
      errors++; $display("FAIL mid_reset valid=%b dec=%0d par=%0d exp 0/0/0", m_valid, dec_err_cnt, parity_err_cnt);
    end
    send_raw(3'b000, 1'b1);
    send_raw(3'b000, 1'b1);
    checks++;
    if (dec_err_cnt !== 8'd0) begin
      errors++; $display("FAIL mid_warm dec=%0d exp 0", dec_err_cnt);
    end
    enc_reset();
    send_data(2'b11, 1'b0, 1'b0);
    send_data(2'b01, 1'b0, 1'b0);
    checks++;
    if (m_valid !== 1'b0) begin
      errors++; $display("FAIL mid_align valid=%b exp 0", m_valid);
    end
    send_data(2'b10, 1'b0, 1'b0);
    checks++;
    if (m_valid !== 1'b1 || m_data !== 4'b0111 || parity_err_cnt !== 8'd0) begin
      errors++; $display("FAIL mid_word valid=%b data=%b par=%0d exp 1/0111/0", m_valid, m_data, parity_err_cnt);
    end
    m_ready = 1'b1;
    for (int i = 0; i < 260; i++) send_raw(3'b010, 1'b0);
    checks++;
    if (parity_err_cnt !== 8'd255) begin
      errors++; $display("FAIL sat_reach got %0d exp 255", parity_err_cnt);
    end
    for (int i = 0; i < 5; i++) send_raw(3'b010, 1'b0);
    checks++;
    if (parity_err_cnt !== 8'd255) begin
      errors++; $display("FAIL sat_hold got %0d exp 255", parity_err_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_unpack();
    test_parity();
    test_overflow();
    test_full_push_pop();
    test_dec_err_clr();
    test_reset_mid_word();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
